// File: rtl/sort_pipe_sched.sv
// Scheduler and controller for the 4-input, 3-stage pipelined bubble sorter:
// round-robin A/B intake, whole-pipe stall, occupancy/tag tracking and output deskew.
module sort_pipe_sched #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [width-1:0] a_in1,
    input  logic [width-1:0] a_in2,
    input  logic [width-1:0] a_in3,
    input  logic [width-1:0] a_in4,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [width-1:0] b_in1,
    input  logic [width-1:0] b_in2,
    input  logic [width-1:0] b_in3,
    input  logic [width-1:0] b_in4,
    output logic             sort_en,
    output logic [width-1:0] sort_in1,
    output logic [width-1:0] sort_in2,
    output logic [width-1:0] sort_in3,
    output logic [width-1:0] sort_in4,
    input  logic [width-1:0] sort_out1,
    input  logic [width-1:0] sort_out2,
    input  logic [width-1:0] sort_out3,
    input  logic [width-1:0] sort_out4,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_tag,
    output logic [width-1:0] res1,
    output logic [width-1:0] res2,
    output logic [width-1:0] res3,
    output logic [width-1:0] res4,
    output logic             busy
);

    logic             r_vld_p0, r_vld_p1, r_vld_p2;
    logic             r_tag_p0, r_tag_p1, r_tag_p2;
    logic             r_last_b;
    logic [width-1:0] r_d3_p2;
    logic [width-1:0] r_d4_p1, r_d4_p2;

    logic w_en;
    logic w_grant_a;
    logic w_grant_b;
    logic w_accept;

    // Reset forces the enable high so a sorter sharing rst flushes with us.
    assign w_en      = rst | ~(r_vld_p2 & ~res_ready);
    assign w_grant_a = a_valid & (~b_valid | r_last_b);
    assign w_grant_b = b_valid & (~a_valid | ~r_last_b);
    assign w_accept  = w_en & ~rst & (a_valid | b_valid);

    assign a_ready = w_accept & w_grant_a;
    assign b_ready = w_accept & w_grant_b;
    assign sort_en = w_en;

    always_comb begin
        sort_in1 = '0;
        sort_in2 = '0;
        sort_in3 = '0;
        sort_in4 = '0;
        if (a_ready) begin
            sort_in1 = a_in1;
            sort_in2 = a_in2;
            sort_in3 = a_in3;
            sort_in4 = a_in4;
        end else if (b_ready) begin
            sort_in1 = b_in1;
            sort_in2 = b_in2;
            sort_in3 = b_in3;
            sort_in4 = b_in4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_tag_p0 <= 1'b0;
            r_tag_p1 <= 1'b0;
            r_tag_p2 <= 1'b0;
            r_last_b <= 1'b1;
            r_d3_p2  <= '0;
            r_d4_p1  <= '0;
            r_d4_p2  <= '0;
        end else if (w_en) begin
            // p0: sorter stage 1 holds the item; its max is already on sort_out4
            r_vld_p0 <= w_accept;
            r_tag_p0 <= b_ready;
            // p1: max delayed once, 3rd element now on sort_out3
            r_vld_p1 <= r_vld_p0;
            r_tag_p1 <= r_tag_p0;
            r_d4_p1  <= sort_out4;
            // p2: max and 3rd aligned with min/2nd coming off the last stage
            r_vld_p2 <= r_vld_p1;
            r_tag_p2 <= r_tag_p1;
            r_d4_p2  <= r_d4_p1;
            r_d3_p2  <= sort_out3;
            if (w_accept) begin
                r_last_b <= w_grant_b;
            end
        end
    end

    assign res_valid = r_vld_p2 & ~rst;
    assign res_tag   = r_tag_p2 & ~rst;
    assign res1      = sort_out1;
    assign res2      = sort_out2;
    assign res3      = rst ? '0 : r_d3_p2;
    assign res4      = rst ? '0 : r_d4_p2;
    assign busy      = (r_vld_p0 | r_vld_p1 | r_vld_p2) & ~rst;

endmodule

// File: tb/tb_sort_pipe_sched.sv
// Bench for sort_pipe_sched: behavioural sorter, queue-based reference model,
// table-driven single vectors, directed multi-cycle sequences and random traffic.
module tb_sort_pipe_sched;
    localparam int W = 8;
    typedef logic [3:0][W-1:0] vec_t;
    typedef struct { vec_t in; logic use_b; vec_t exp; } vrec_t;
    typedef struct { vec_t e; logic tag; int age; } item_t;

    logic clk = 1'b0;
    logic rst, a_valid, a_ready, b_valid, b_ready, sort_en;
    logic res_valid, res_ready, res_tag, busy;
    logic [W-1:0] sort_in1, sort_in2, sort_in3, sort_in4;
    logic [W-1:0] sort_out1, sort_out2, sort_out3, sort_out4;
    logic [W-1:0] res1, res2, res3, res4;
    vec_t a_vec, b_vec;
    vec_t s0, s1, s2;

    int n_tot = 0;
    int n_pass = 0;
    item_t q[$];
    logic m_last_b, m_rv, m_en, m_ga, m_gb;

    always #5 clk = ~clk;

    sort_pipe_sched #(.width(W)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready),
        .a_in1(a_vec[0]), .a_in2(a_vec[1]), .a_in3(a_vec[2]), .a_in4(a_vec[3]),
        .b_valid(b_valid), .b_ready(b_ready),
        .b_in1(b_vec[0]), .b_in2(b_vec[1]), .b_in3(b_vec[2]), .b_in4(b_vec[3]),
        .sort_en(sort_en),
        .sort_in1(sort_in1), .sort_in2(sort_in2), .sort_in3(sort_in3), .sort_in4(sort_in4),
        .sort_out1(sort_out1), .sort_out2(sort_out2), .sort_out3(sort_out3), .sort_out4(sort_out4),
        .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
        .res1(res1), .res2(res2), .res3(res3), .res4(res4),
        .busy(busy)
    );

    function automatic vec_t sort4(vec_t v);
        vec_t r = v;
        logic [W-1:0] tmp;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 3 - i; j++)
                if (r[j] > r[j+1]) begin
                    tmp = r[j]; r[j] = r[j+1]; r[j+1] = tmp;
                end
        return r;
    endfunction

    function automatic vec_t mk(int x1, int x2, int x3, int x4);
        vec_t v;
        v[0] = W'(x1); v[1] = W'(x2); v[2] = W'(x3); v[3] = W'(x4);
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < 4; i++)
            v[i] = ($urandom % 4 == 0) ? (($urandom % 2 == 1) ? 8'hff : 8'h00) : W'($urandom);
        return v;
    endfunction

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endfunction

    // External 3-stage sorter: max out after 1 enabled edge, 3rd after 2, min/2nd after 3.
    always @(posedge clk) begin
        if (rst) begin
            s0 <= '0; s1 <= '0; s2 <= '0;
        end else if (sort_en) begin
            s0 <= sort4({sort_in4, sort_in3, sort_in2, sort_in1});
            s1 <= s0;
            s2 <= s1;
        end
    end
    assign sort_out4 = s0[3];
    assign sort_out3 = s1[2];
    assign sort_out1 = s2[0];
    assign sort_out2 = s2[1];

    // Reference model: in-flight items with their count of enabled edges since acceptance.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_res_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", {a_ready, b_ready}, 0);
            chk("rst_sort_en", sort_en, 1);
            chk("rst_res34", {res3, res4, 7'd0, res_tag}, 0);
            q.delete();
            m_last_b = 1'b1;
        end else begin
            m_rv = (q.size() > 0) && (q[0].age >= 3);
            m_en = !(m_rv && !res_ready);
            m_ga = m_en && a_valid && (!b_valid || m_last_b);
            m_gb = m_en && b_valid && (!a_valid || !m_last_b);
            chk("res_valid", res_valid, m_rv);
            chk("sort_en", sort_en, m_en);
            chk("a_ready", a_ready, m_ga);
            chk("b_ready", b_ready, m_gb);
            chk("busy", busy, q.size() > 0);
            if (m_rv) begin
                chk("res_data", {res4, res3, res2, res1}, q[0].e);
                chk("res_tag", res_tag, q[0].tag);
            end
            if (m_en) begin
                if (m_rv && res_ready) void'(q.pop_front());
                for (int i = 0; i < q.size(); i++) q[i].age++;
                if (m_ga) begin
                    q.push_back('{sort4(a_vec), 1'b0, 1});
                    m_last_b = 1'b0;
                end else if (m_gb) begin
                    q.push_back('{sort4(b_vec), 1'b1, 1});
                    m_last_b = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vrec_t tbl[5];
        vec_t bb_in[3], bb_exp[3], bp_in[4], bp_exp[4], held;
        logic exp_g[6];
        logic grants[$], tags[$];
        logic a_acc, b_acc;

        rst = 1'b1; a_valid = 0; b_valid = 0; res_ready = 1'b1;
        a_vec = '0; b_vec = '0;

        tbl[0] = '{mk(5, 9, 1, 7),       1'b0, mk(1, 5, 7, 9)};
        tbl[1] = '{mk(255, 255, 0, 0),   1'b0, mk(0, 0, 255, 255)};
        tbl[2] = '{mk(7, 7, 7, 7),       1'b1, mk(7, 7, 7, 7)};
        tbl[3] = '{mk(0, 255, 128, 1),   1'b1, mk(0, 1, 128, 255)};
        tbl[4] = '{mk(4, 3, 2, 1),       1'b0, mk(1, 2, 3, 4)};

        // Reset state
        tick; tick; smp;
        chk("reset_state", {res_valid, busy, a_ready, b_ready, res3, res4}, 0);
        tick; rst = 1'b0; smp;
        chk("idle_after_reset", {res_valid, busy}, 0);

        // Single vectors: ready same cycle, busy 3 cycles, result 3 cycles later
        for (int i = 0; i < 5; i++) begin
            tick;
            if (tbl[i].use_b) begin b_valid = 1; b_vec = tbl[i].in; end
            else begin a_valid = 1; a_vec = tbl[i].in; end
            smp;
            chk("tbl_idle", busy, 0);
            chk("tbl_ready", tbl[i].use_b ? b_ready : a_ready, 1);
            for (int c = 1; c <= 3; c++) begin
                tick; a_valid = 0; b_valid = 0; smp;
                chk("tbl_busy", busy, 1);
                chk("tbl_valid", res_valid, (c == 3));
            end
            chk("tbl_res", {res4, res3, res2, res1}, tbl[i].exp);
            chk("tbl_tag", res_tag, tbl[i].use_b);
        end

        // Back-to-back stream
        bb_in[0] = mk(4, 3, 2, 1);      bb_exp[0] = mk(1, 2, 3, 4);
        bb_in[1] = mk(8, 8, 0, 255);    bb_exp[1] = mk(0, 8, 8, 255);
        bb_in[2] = mk(10, 20, 30, 40);  bb_exp[2] = mk(10, 20, 30, 40);
        for (int c = 0; c < 6; c++) begin
            tick;
            a_valid = (c < 3);
            if (c < 3) a_vec = bb_in[c];
            smp;
            if (c < 3) chk("bb_ready", a_ready, 1);
            else begin
                chk("bb_valid", res_valid, 1);
                chk("bb_res", {res4, res3, res2, res1}, bb_exp[c-3]);
            end
        end

        // Backpressure: 4-cycle stall from the first result, 4th vector waits
        bp_in[0] = mk(3, 1, 2, 0);        bp_exp[0] = mk(0, 1, 2, 3);
        bp_in[1] = mk(100, 50, 200, 25);  bp_exp[1] = mk(25, 50, 100, 200);
        bp_in[2] = mk(9, 9, 1, 1);        bp_exp[2] = mk(1, 1, 9, 9);
        bp_in[3] = mk(60, 61, 62, 63);    bp_exp[3] = mk(60, 61, 62, 63);
        held = '0;
        for (int c = 0; c < 12; c++) begin
            tick;
            a_valid = (c <= 7);
            a_vec = bp_in[(c < 3) ? c : 3];
            res_ready = !(c >= 3 && c <= 6);
            smp;
            if (c < 3) chk("bp_accept", a_ready, 1);
            if (c == 3) held = {res4, res3, res2, res1};
            if (c >= 3 && c <= 6) begin
                chk("bp_stall_en", {sort_en, a_ready}, 0);
                chk("bp_hold", {res4, res3, res2, res1}, held);
                chk("bp_hold_res", {res4, res3, res2, res1}, bp_exp[0]);
                chk("bp_hold_valid", {res_valid, res_tag}, 2'b10);
            end
            if (c == 7) chk("bp_release", {sort_en, a_ready}, 2'b11);
            if (c >= 7 && c <= 10) begin
                chk("bp_drain_valid", res_valid, 1);
                chk("bp_drain_res", {res4, res3, res2, res1}, bp_exp[c-7]);
            end
            if (c == 11) chk("bp_empty", {res_valid, busy}, 0);
        end
        res_ready = 1'b1;

        // Reset with two vectors in flight
        for (int c = 0; c < 8; c++) begin
            tick;
            a_valid = (c < 2);
            a_vec = mk(c + 20, 1, 2, 3);
            rst = (c == 2);
            smp;
            if (c == 2) chk("mid_rst_en", sort_en, 1);
            if (c >= 3) chk("post_rst", {res_valid, busy, res3, res4}, 0);
        end

        // Round-robin: both valid for 4 accepts, then only B
        exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        a_acc = 1; b_acc = 1;
        for (int c = 0; c < 12; c++) begin
            tick;
            a_valid = (c < 4);
            b_valid = (c < 6);
            if (a_acc) a_vec = rnd_vec();
            if (b_acc) b_vec = rnd_vec();
            smp;
            a_acc = a_ready; b_acc = b_ready;
            if (a_ready) grants.push_back(1'b0);
            if (b_ready) grants.push_back(1'b1);
            if (res_valid) tags.push_back(res_tag);
        end
        chk("rr_grant_count", grants.size(), 6);
        chk("rr_tag_count", tags.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < grants.size()) chk("rr_grant", grants[i], exp_g[i]);
            if (i < tags.size()) chk("rr_tag", tags[i], exp_g[i]);
        end

        // Random traffic against the reference model
        a_acc = 1; b_acc = 1;
        repeat (800) begin
            tick;
            rst = ($urandom % 150 == 0);
            if (!a_valid || a_acc) begin a_valid = ($urandom % 3 != 0); a_vec = rnd_vec(); end
            if (!b_valid || b_acc) begin b_valid = ($urandom % 3 != 0); b_vec = rnd_vec(); end
            res_ready = ($urandom % 4 != 0);
            smp;
            a_acc = a_ready; b_acc = b_ready;
        end
        tick; rst = 0; a_valid = 0; b_valid = 0; res_ready = 1;
        repeat (6) begin tick; smp; end
        chk("drain_model_empty", q.size(), 0);
        chk("drain_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
